// File: rtl/rx_dpram_writer.sv
// rx_dpram_writer
//
// Takes 16-bit receive words from the DM9000A RX controller, splits each word
// into two bytes and writes them one per cycle into port B of the shared
// 1024x8 frame DPRAM. When the last word has been stored, the byte length is
// published on oRxLen and oFrameReady is held high. The downstream
// DPRAM-to-FIFO stage uses that level as its run-start and releases the frame
// with iFrameAck.
//
// Ports:
//   iDm9000aClk   system clock, rising edge
//   iReset        asynchronous active-high reset
//   iRxStart      one-cycle pulse, start of a new frame (honoured in IDLE only)
//   iRxWordValid  iRxWord valid; taken while oWordReady=1
//   iRxWord       received word, [7:0] is the first byte on the wire
//   iRxLast       accepted word is the last one of the frame
//   iRxOdd        with iRxLast: only one byte of the last word is valid
//   oWordReady    block can take a word this cycle
//   address_b     DPRAM port B address
//   data_b        DPRAM port B write data
//   wren_b        DPRAM port B write enable
//   oRxLen        frame byte count, valid while oFrameReady=1
//   oFrameReady   frame stored, held until iFrameAck
//   iFrameAck     downstream run-end, releases the frame
//   oOverflow     sticky: the frame had more than MAX_LEN bytes
//
// Build option:
//   RX_BYTE_SWAP_EN  when defined, iRxWord[15:8] is stored first and
//                    iRxWord[7:0] second; an odd last word keeps only [15:8].
//                    When undefined, [7:0] is stored first.

module rx_dpram_writer #(
    parameter int ADDR_W  = 10,
    parameter int MAX_LEN = 1024
) (
    input  logic              iDm9000aClk,
    input  logic              iReset,
    input  logic              iRxStart,
    input  logic              iRxWordValid,
    input  logic [15:0]       iRxWord,
    input  logic              iRxLast,
    input  logic              iRxOdd,
    output logic              oWordReady,
    output logic [ADDR_W-1:0] address_b,
    output logic [7:0]        data_b,
    output logic              wren_b,
    output logic [15:0]       oRxLen,
    output logic              oFrameReady,
    input  logic              iFrameAck,
    output logic              oOverflow
);

    // One extra bit so the counter can reach MAX_LEN itself.
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LEN);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_WORD,
        WR_LO,
        WR_HI,
        READY
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] byte_cnt;
    logic [7:0]       pend_byte;
    logic             last_q;
    logic             odd_q;

    logic [7:0]       first_byte_in;
    logic [7:0]       second_byte_in;
    logic             room_now;
    logic             room_next;
    logic [CNT_W-1:0] cnt_after;

    // Byte order of an incoming word. Only the second byte needs to be kept,
    // the first one goes straight to the DPRAM port on the accepting edge.
`ifdef RX_BYTE_SWAP_EN
    assign first_byte_in  = iRxWord[15:8];
    assign second_byte_in = iRxWord[7:0];
`else
    assign first_byte_in  = iRxWord[7:0];
    assign second_byte_in = iRxWord[15:8];
`endif

    // room_now: the byte being written in the current WR_LO/WR_HI cycle (or
    // about to be written, seen from WAIT_WORD) fits in the DPRAM.
    // cnt_after: counter once that byte is accounted for; it saturates at
    // MAX_LEN so the address never wraps.
    // room_next: the following byte fits as well.
    assign room_now  = (byte_cnt < MAX_CNT);
    assign cnt_after = room_now ? byte_cnt + 1'b1 : byte_cnt;
    assign room_next = (cnt_after < MAX_CNT);

    // Frame FSM. Every output is a register loaded on the edge that enters the
    // state it belongs to, so the write strobe for a byte is visible during
    // the WR_LO/WR_HI cycle itself. The counter is advanced while leaving the
    // write state, which is why the next byte's address is taken from
    // cnt_after rather than byte_cnt.
    always_ff @(posedge iDm9000aClk or posedge iReset) begin
        if (iReset) begin
            state       <= IDLE;
            byte_cnt    <= '0;
            pend_byte   <= '0;
            last_q      <= 1'b0;
            odd_q       <= 1'b0;
            oWordReady  <= 1'b0;
            address_b   <= '0;
            data_b      <= '0;
            wren_b      <= 1'b0;
            oRxLen      <= '0;
            oFrameReady <= 1'b0;
            oOverflow   <= 1'b0;
        end else begin
            // A write strobe never lasts more than one cycle.
            wren_b <= 1'b0;

            case (state)
                IDLE: begin
                    if (iRxStart) begin
                        state      <= WAIT_WORD;
                        byte_cnt   <= '0;
                        oOverflow  <= 1'b0;
                        oRxLen     <= '0;
                        oWordReady <= 1'b1;
                    end
                end

                WAIT_WORD: begin
                    if (iRxWordValid) begin
                        state      <= WR_LO;
                        oWordReady <= 1'b0;
                        pend_byte  <= second_byte_in;
                        last_q     <= iRxLast;
                        odd_q      <= iRxOdd;
                        if (room_now) begin
                            wren_b    <= 1'b1;
                            address_b <= byte_cnt[ADDR_W-1:0];
                            data_b    <= first_byte_in;
                        end else begin
                            oOverflow <= 1'b1;
                        end
                    end
                end

                WR_LO: begin
                    byte_cnt <= cnt_after;
                    // iRxOdd only matters on the last word.
                    if (last_q && odd_q) begin
                        state       <= READY;
                        oFrameReady <= 1'b1;
                        oRxLen      <= 16'(cnt_after);
                    end else begin
                        state <= WR_HI;
                        if (room_next) begin
                            wren_b    <= 1'b1;
                            address_b <= cnt_after[ADDR_W-1:0];
                            data_b    <= pend_byte;
                        end else begin
                            oOverflow <= 1'b1;
                        end
                    end
                end

                WR_HI: begin
                    byte_cnt <= cnt_after;
                    if (last_q) begin
                        state       <= READY;
                        oFrameReady <= 1'b1;
                        oRxLen      <= 16'(cnt_after);
                    end else begin
                        state      <= WAIT_WORD;
                        oWordReady <= 1'b1;
                    end
                end

                READY: begin
                    // oRxLen stays put until the next iRxStart in IDLE.
                    if (iFrameAck) begin
                        state       <= IDLE;
                        oFrameReady <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rx_dpram_writer.sv
// tb_rx_dpram_writer
//
// Drives whole frames into rx_dpram_writer and checks every DPRAM write
// against a queue of expected {address, data} pairs built from the words
// sent, then checks length, overflow and the frame-ready handshake.
// Frame cases are listed in a table; the start-pulse, back-to-back and
// mid-frame reset cases are written out by hand.

module tb_rx_dpram_writer;

    localparam int ADDR_W  = 10;
    localparam int MAX_LEN = 1024;

    logic              clk;
    logic              rst;
    logic              iRxStart;
    logic              iRxWordValid;
    logic [15:0]       iRxWord;
    logic              iRxLast;
    logic              iRxOdd;
    logic              oWordReady;
    logic [ADDR_W-1:0] address_b;
    logic [7:0]        data_b;
    logic              wren_b;
    logic [15:0]       oRxLen;
    logic              oFrameReady;
    logic              iFrameAck;
    logic              oOverflow;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int model_bytes = 0;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
    } wr_t;

    wr_t exp_q[$];

    typedef struct packed {
        int             nwords;
        logic [3:0][15:0] words;
        bit             odd;
        bit             noise;
        int             exp_len;
        bit             exp_ovf;
    } vec_t;

    vec_t vecs[5];

    rx_dpram_writer #(
        .ADDR_W (ADDR_W),
        .MAX_LEN(MAX_LEN)
    ) dut (
        .iDm9000aClk (clk),
        .iReset      (rst),
        .iRxStart    (iRxStart),
        .iRxWordValid(iRxWordValid),
        .iRxWord     (iRxWord),
        .iRxLast     (iRxLast),
        .iRxOdd      (iRxOdd),
        .oWordReady  (oWordReady),
        .address_b   (address_b),
        .data_b      (data_b),
        .wren_b      (wren_b),
        .oRxLen      (oRxLen),
        .oFrameReady (oFrameReady),
        .iFrameAck   (iFrameAck),
        .oOverflow   (oOverflow)
    );

    // Free-running clock and a cycle counter for spacing measurements.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Watchdog so the run always ends, even if something stalls.
    initial begin
        #600000;
        $display("[TB] FAIL watchdog: got no end of test, expected finish before timeout");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Expected-write model: one entry per byte that fits in the DPRAM.
    task automatic pushByte(input logic [7:0] b);
        wr_t e;
        if (model_bytes < MAX_LEN) begin
            e.addr = ADDR_W'(model_bytes);
            e.data = b;
            exp_q.push_back(e);
        end
        model_bytes++;
    endtask

    task automatic pushWord(input logic [15:0] w, input bit last, input bit odd);
        logic [7:0] b0;
        logic [7:0] b1;
`ifdef RX_BYTE_SWAP_EN
        b0 = w[15:8];
        b1 = w[7:0];
`else
        b0 = w[7:0];
        b1 = w[15:8];
`endif
        pushByte(b0);
        if (!(last && odd)) pushByte(b1);
    endtask

    // Write monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (!rst && wren_b) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_write: got addr %0d data %02h, expected no write",
                         address_b, data_b);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                checkOutput("write_addr", 32'(address_b), 32'(e.addr));
                checkOutput("write_data", 32'(data_b), 32'(e.data));
            end
        end
    end

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_wordready"}, 32'(oWordReady), 32'd0);
        checkOutput({tag, "_address"},   32'(address_b),  32'd0);
        checkOutput({tag, "_data"},      32'(data_b),     32'd0);
        checkOutput({tag, "_wren"},      32'(wren_b),     32'd0);
        checkOutput({tag, "_rxlen"},     32'(oRxLen),     32'd0);
        checkOutput({tag, "_frameready"},32'(oFrameReady),32'd0);
        checkOutput({tag, "_overflow"},  32'(oOverflow),  32'd0);
    endtask

    task automatic startFrame();
        iRxStart = 1'b1;
        @(posedge clk); #1;
        iRxStart = 1'b0;
        model_bytes = 0;
        checkOutput("ready_after_start", 32'(oWordReady), 32'd1);
        checkOutput("overflow_cleared",  32'(oOverflow),  32'd0);
    endtask

    // Present one word and wait (bounded) for the edge that accepts it.
    task automatic sendWord(input logic [15:0] w, input bit last, input bit odd,
                            input bit hold_valid, output int acc_cycle);
        int guard;
        iRxWord      = w;
        iRxLast      = last;
        iRxOdd       = odd;
        iRxWordValid = 1'b1;
        guard = 0;
        while (!oWordReady && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!oWordReady) begin
            checks++;
            errors++;
            $display("[TB] FAIL word_ready_timeout: got 0 expected 1 within 20 cycles");
        end
        pushWord(w, last, odd);
        acc_cycle = cyc;
        @(posedge clk); #1;
        if (!hold_valid) iRxWordValid = 1'b0;
    endtask

    task automatic finishFrame(input int exp_len, input bit exp_ovf, input bit pulse_start);
        int guard;
        guard = 0;
        while (!oFrameReady && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        checkOutput("frame_ready",      32'(oFrameReady), 32'd1);
        checkOutput("rx_len",           32'(oRxLen),      32'(exp_len));
        checkOutput("overflow",         32'(oOverflow),   32'(exp_ovf));
        checkOutput("no_ready_in_done", 32'(oWordReady),  32'd0);
        checkOutput("writes_drained",   32'(exp_q.size()),32'd0);
        repeat (2) begin
            @(posedge clk); #1;
        end
        checkOutput("frame_ready_held", 32'(oFrameReady), 32'd1);
        if (pulse_start) begin
            iRxStart = 1'b1;
            @(posedge clk); #1;
            iRxStart = 1'b0;
            checkOutput("start_in_ready_frame", 32'(oFrameReady), 32'd1);
            checkOutput("start_in_ready_len",   32'(oRxLen),      32'(exp_len));
            checkOutput("start_in_ready_word",  32'(oWordReady),  32'd0);
        end
        iFrameAck = 1'b1;
        @(posedge clk); #1;
        iFrameAck = 1'b0;
        checkOutput("frame_released", 32'(oFrameReady), 32'd0);
        checkOutput("idle_not_ready", 32'(oWordReady),  32'd0);
    endtask

    // Run one table row as a complete frame.
    task automatic applyStimulus(input vec_t v);
        logic [15:0] w;
        bit          last;
        int          acc;
        startFrame();
        for (int i = 0; i < v.nwords; i++) begin
            if (v.nwords <= 4) w = v.words[i];
            else               w = {8'(2 * i + 1), 8'(2 * i)};
            last = (i == v.nwords - 1);
            sendWord(w, last, last ? v.odd : v.noise, 1'b0, acc);
        end
        finishFrame(v.exp_len, v.exp_ovf, 1'b0);
    endtask

    initial begin
        int acc[4];
        int dummy;

        // nwords, words (index 0 first), odd on last, odd on other words,
        // expected length, expected overflow
        vecs[0] = '{nwords: 3, words: {16'h0000, 16'h6655, 16'h4433, 16'h2211},
                    odd: 1'b0, noise: 1'b1, exp_len: 6, exp_ovf: 1'b0};
        vecs[1] = '{nwords: 2, words: {16'h0000, 16'h0000, 16'h00CC, 16'hBBAA},
                    odd: 1'b1, noise: 1'b0, exp_len: 3, exp_ovf: 1'b0};
        vecs[2] = '{nwords: 600, words: '0,
                    odd: 1'b0, noise: 1'b0, exp_len: 1024, exp_ovf: 1'b1};
        vecs[3] = '{nwords: 1, words: {16'h0000, 16'h0000, 16'h0000, 16'h2211},
                    odd: 1'b1, noise: 1'b0, exp_len: 1, exp_ovf: 1'b0};
        vecs[4] = '{nwords: 1, words: {16'h0000, 16'h0000, 16'h0000, 16'hA55A},
                    odd: 1'b0, noise: 1'b0, exp_len: 2, exp_ovf: 1'b0};

        rst          = 1'b1;
        iRxStart     = 1'b0;
        iRxWordValid = 1'b0;
        iRxWord      = '0;
        iRxLast      = 1'b0;
        iRxOdd       = 1'b0;
        iFrameAck    = 1'b0;

        #12;
        checkAllZero("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        // Stray inputs in IDLE must not start anything.
        iRxWordValid = 1'b1;
        iFrameAck    = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        iRxWordValid = 1'b0;
        iFrameAck    = 1'b0;
        checkAllZero("idle");

        for (int i = 0; i < 5; i++) begin
            $display("[TB] table row %0d", i);
            applyStimulus(vecs[i]);
        end

        // iRxStart during WR_HI and during READY is ignored.
        $display("[TB] start pulses mid-frame");
        startFrame();
        sendWord(16'h1357, 1'b0, 1'b0, 1'b0, dummy);
        @(posedge clk); #1;
        iRxStart = 1'b1;
        @(posedge clk); #1;
        iRxStart = 1'b0;
        sendWord(16'h2468, 1'b1, 1'b0, 1'b0, dummy);
        finishFrame(4, 1'b0, 1'b1);

        // Valid held high: one word every 3 cycles.
        $display("[TB] valid held high");
        startFrame();
        for (int i = 0; i < 4; i++) begin
            sendWord(16'(16'hC0D0 + i * 16'h0101), (i == 3), 1'b0, 1'b1, acc[i]);
        end
        iRxWordValid = 1'b0;
        for (int i = 1; i < 4; i++) begin
            checkOutput("accept_spacing", 32'(acc[i] - acc[i-1]), 32'd3);
        end
        finishFrame(8, 1'b0, 1'b0);

        // Reset in WR_LO of word 2 abandons the frame.
        $display("[TB] reset mid-frame");
        startFrame();
        sendWord(16'h7788, 1'b0, 1'b0, 1'b0, dummy);
        sendWord(16'h99AA, 1'b0, 1'b0, 1'b0, dummy);
        rst = 1'b1;
        #1;
        checkAllZero("midreset");
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        checkOutput("post_reset_idle", 32'(oWordReady), 32'd0);
        applyStimulus(vecs[0]);

        checkOutput("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
